// File: rtl/mult_div_unit.sv
// Iterative MULT/MULTU/DIV/DIVU unit owning HI/LO; fixed 33-edge latency.
// Ports: clk, reset_n, start/op/a/b request, hi_we/lo_we/wdata MT writes, busy/done/hi/lo.
module mult_div_unit #(
  parameter int WIDTH = 32,
  parameter int ITER  = 32
) (
  input  logic             clk,
  input  logic             reset_n,
  input  logic             start,
  input  logic [1:0]       op,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             hi_we,
  input  logic             lo_we,
  input  logic [WIDTH-1:0] wdata,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] hi,
  output logic [WIDTH-1:0] lo
);

  localparam int CW = $clog2(ITER) + 1;
  localparam logic [CW-1:0] LAST = CW'(ITER - 1);

  typedef enum logic [1:0] {
    S_IDLE,
    S_MUL,
    S_DIV,
    S_FIX
  } state_e;

  state_e               state_q, state_d;
  logic [CW-1:0]        cnt_q, cnt_d;
  logic [2*WIDTH-1:0]   acc_q, acc_d;
  logic [WIDTH-1:0]     opnd_q, opnd_d;
  logic [WIDTH-1:0]     orig_q, orig_d;
  logic                 isdiv_q, isdiv_d;
  logic                 dz_q, dz_d;
  logic                 negp_q, negp_d;
  logic                 negr_q, negr_d;
  logic [WIDTH-1:0]     hi_q, hi_d;
  logic [WIDTH-1:0]     lo_q, lo_d;
  logic                 done_q, done_d;

  logic                 sa, sb;
  logic [WIDTH-1:0]     mag_a, mag_b;
  logic [WIDTH:0]       sum;
  logic [2*WIDTH-1:0]   acc_mul, acc_div;
  logic [WIDTH:0]       rem_sh;
  logic [WIDTH-1:0]     diff;
  logic                 ge;
  logic [2*WIDTH-1:0]   prod;
  logic [WIDTH-1:0]     quo, rem;

  // Operand magnitudes; op[0]=0 selects signed
  always_comb begin
    sa    = ~op[0] & a[WIDTH-1];
    sb    = ~op[0] & b[WIDTH-1];
    mag_a = sa ? ('0 - a) : a;
    mag_b = sb ? ('0 - b) : b;
  end

  // Datapath steps: acc holds {partial, multiplier/quotient}
  always_comb begin
    sum     = {1'b0, acc_q[2*WIDTH-1:WIDTH]}
            + (acc_q[0] ? {1'b0, opnd_q} : '0);
    acc_mul = {sum, acc_q[WIDTH-1:1]};
    rem_sh  = acc_q[2*WIDTH-1:WIDTH-1];
    ge      = rem_sh >= {1'b0, opnd_q};
    diff    = rem_sh[WIDTH-1:0] - opnd_q;
    acc_div = ge ? {diff, acc_q[WIDTH-2:0], 1'b1}
                 : {rem_sh[WIDTH-1:0], acc_q[WIDTH-2:0], 1'b0};
    prod    = negp_q ? ('0 - acc_q) : acc_q;
    quo     = negp_q ? ('0 - acc_q[WIDTH-1:0]) : acc_q[WIDTH-1:0];
    rem     = negr_q ? ('0 - acc_q[2*WIDTH-1:WIDTH])
                     : acc_q[2*WIDTH-1:WIDTH];
  end

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    acc_d   = acc_q;
    opnd_d  = opnd_q;
    orig_d  = orig_q;
    isdiv_d = isdiv_q;
    dz_d    = dz_q;
    negp_d  = negp_q;
    negr_d  = negr_q;
    hi_d    = hi_q;
    lo_d    = lo_q;
    done_d  = 1'b0;
    unique case (state_q)
      S_IDLE: begin
        if (hi_we) hi_d = wdata;
        if (lo_we) lo_d = wdata;
        if (start) begin
          state_d = op[1] ? S_DIV : S_MUL;
          cnt_d   = '0;
          acc_d   = {{WIDTH{1'b0}}, op[1] ? mag_a : mag_b};
          opnd_d  = op[1] ? mag_b : mag_a;
          orig_d  = a;
          isdiv_d = op[1];
          dz_d    = op[1] & (b == '0);
          negp_d  = sa ^ sb;
          negr_d  = sa;
        end
      end
      S_MUL: begin
        acc_d = acc_mul;
        cnt_d = cnt_q + CW'(1);
        if (cnt_q == LAST) state_d = S_FIX;
      end
      S_DIV: begin
        acc_d = acc_div;
        cnt_d = cnt_q + CW'(1);
        if (cnt_q == LAST) state_d = S_FIX;
      end
      S_FIX: begin
        // Divide by zero returns the untouched dividend in HI
        if (dz_q) begin
          hi_d = orig_q;
          lo_d = '1;
        end else if (isdiv_q) begin
          hi_d = rem;
          lo_d = quo;
        end else begin
          hi_d = prod[2*WIDTH-1:WIDTH];
          lo_d = prod[WIDTH-1:0];
        end
        done_d  = 1'b1;
        state_d = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!reset_n) begin
      state_q <= S_IDLE;
      cnt_q   <= '0;
      acc_q   <= '0;
      opnd_q  <= '0;
      orig_q  <= '0;
      isdiv_q <= 1'b0;
      dz_q    <= 1'b0;
      negp_q  <= 1'b0;
      negr_q  <= 1'b0;
      hi_q    <= '0;
      lo_q    <= '0;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      acc_q   <= acc_d;
      opnd_q  <= opnd_d;
      orig_q  <= orig_d;
      isdiv_q <= isdiv_d;
      dz_q    <= dz_d;
      negp_q  <= negp_d;
      negr_q  <= negr_d;
      hi_q    <= hi_d;
      lo_q    <= lo_d;
      done_q  <= done_d;
    end
  end

  assign busy = (state_q != S_IDLE);
  assign done = done_q;
  assign hi   = hi_q;
  assign lo   = lo_q;

endmodule

// File: tb/tb_mult_div_unit.sv
// Bench for mult_div_unit: directed vector table, corner sequences,
// and random ops against an arithmetic reference model.
module tb_mult_div_unit;

  logic        clk = 1'b0;
  logic        reset_n;
  logic        start;
  logic [1:0]  op;
  logic [31:0] a, b;
  logic        hi_we, lo_we;
  logic [31:0] wdata;
  logic        busy, done;
  logic [31:0] hi, lo;

  int checks = 0;
  int errors = 0;
  int ovl = 0;

  always #5 clk = ~clk;

  mult_div_unit #(.WIDTH(32), .ITER(32)) dut (
    .clk(clk), .reset_n(reset_n), .start(start), .op(op),
    .a(a), .b(b), .hi_we(hi_we), .lo_we(lo_we), .wdata(wdata),
    .busy(busy), .done(done), .hi(hi), .lo(lo)
  );

  typedef struct {
    string       nm;
    logic [1:0]  op;
    logic [31:0] a;
    logic [31:0] b;
    logic [31:0] eh;
    logic [31:0] el;
  } vec_t;

  vec_t vt[11];

  task automatic chk(input string nm, input logic [31:0] act,
                     input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s act=%h exp=%h", nm, act, exp);
    end
  endtask

  function automatic logic [63:0] ref_model(input logic [1:0] o,
                                            input logic [31:0] x,
                                            input logic [31:0] y);
    logic signed [63:0] sx, sy;
    int sq, sr, ix, iy;
    logic [63:0] r;
    sx = {{32{x[31]}}, x};
    sy = {{32{y[31]}}, y};
    ix = x;
    iy = y;
    r = '0;
    case (o)
      2'd0: r = sx * sy;
      2'd1: r = {32'h0, x} * {32'h0, y};
      2'd2: begin
        if (y == 0) r = {x, 32'hFFFFFFFF};
        else if (x == 32'h80000000 && y == 32'hFFFFFFFF)
          r = {32'h0, 32'h80000000};
        else begin
          sq = ix / iy;
          sr = ix % iy;
          r = {sr, sq};
        end
      end
      default: begin
        if (y == 0) r = {x, 32'hFFFFFFFF};
        else r = {x % y, x / y};
      end
    endcase
    return r;
  endfunction

  task automatic launch(input logic [1:0] o, input logic [31:0] x,
                        input logic [31:0] y);
    start = 1'b1;
    op    = o;
    a     = x;
    b     = y;
    @(posedge clk);
    #1;
    start = 1'b0;
    hi_we = 1'b0;
    lo_we = 1'b0;
    a     = $urandom;
    b     = $urandom;
    op    = 2'($urandom_range(0, 3));
  endtask

  // k counts edges after the accepting edge
  task automatic wait_done(input int k0, output int lat, output int bn);
    lat = -1;
    bn  = 0;
    for (int k = k0; k < k0 + 45; k++) begin
      if (busy && done) ovl++;
      if (done) begin
        lat = k;
        break;
      end
      if (busy) bn++;
      @(posedge clk);
      #1;
    end
  endtask

  task automatic do_op(input logic [1:0] o, input logic [31:0] x,
                       input logic [31:0] y, output int lat,
                       output int bn);
    launch(o, x, y);
    wait_done(0, lat, bn);
  endtask

  initial begin
    int lat, bn, dn;
    logic [63:0] r;
    logic [31:0] xs, ys, ra, rb;
    logic [1:0]  ro;

    vt[0]  = '{"multu_ff", 2'd1, 32'hFFFFFFFF, 32'hFFFFFFFF,
               32'hFFFFFFFE, 32'h00000001};
    vt[1]  = '{"mult_m3x7", 2'd0, 32'hFFFFFFFD, 32'd7,
               32'hFFFFFFFF, 32'hFFFFFFEB};
    vt[2]  = '{"div_m7_2", 2'd2, 32'hFFFFFFF9, 32'd2,
               32'hFFFFFFFF, 32'hFFFFFFFD};
    vt[3]  = '{"divu_100_7", 2'd3, 32'd100, 32'd7, 32'd2, 32'd14};
    vt[4]  = '{"div_ovf", 2'd2, 32'h80000000, 32'hFFFFFFFF,
               32'h0, 32'h80000000};
    vt[5]  = '{"divu_dz", 2'd3, 32'd100, 32'd0,
               32'h00000064, 32'hFFFFFFFF};
    vt[6]  = '{"div_dz", 2'd2, 32'hFFFFFFFB, 32'd0,
               32'hFFFFFFFB, 32'hFFFFFFFF};
    vt[7]  = '{"mult_min2", 2'd0, 32'h80000000, 32'h80000000,
               32'h40000000, 32'h0};
    vt[8]  = '{"mult_min1", 2'd0, 32'h80000000, 32'd1,
               32'hFFFFFFFF, 32'h80000000};
    vt[9]  = '{"divu_max1", 2'd3, 32'hFFFFFFFF, 32'd1,
               32'h0, 32'hFFFFFFFF};
    vt[10] = '{"div_7_m2", 2'd2, 32'd7, 32'hFFFFFFFE,
               32'd1, 32'hFFFFFFFD};

    reset_n = 1'b0;
    start   = 1'b0;
    op      = 2'd0;
    a       = '0;
    b       = '0;
    hi_we   = 1'b0;
    lo_we   = 1'b0;
    wdata   = '0;
    repeat (3) @(posedge clk);
    #1;
    chk("rst_busy", 32'(busy), 32'd0);
    chk("rst_done", 32'(done), 32'd0);
    chk("rst_hi", hi, 32'h0);
    chk("rst_lo", lo, 32'h0);
    reset_n = 1'b1;

    // MT writes while idle, both and then one
    hi_we = 1'b1;
    lo_we = 1'b1;
    wdata = 32'hA5A5A5A5;
    @(posedge clk);
    #1;
    hi_we = 1'b0;
    lo_we = 1'b0;
    chk("mt_both_hi", hi, 32'hA5A5A5A5);
    chk("mt_both_lo", lo, 32'hA5A5A5A5);
    lo_we = 1'b1;
    wdata = 32'h0000BEEF;
    @(posedge clk);
    #1;
    lo_we = 1'b0;
    chk("mt_lo_hi", hi, 32'hA5A5A5A5);
    chk("mt_lo_lo", lo, 32'h0000BEEF);

    // Back-to-back: each op starts in the previous done cycle
    foreach (vt[i]) begin
      do_op(vt[i].op, vt[i].a, vt[i].b, lat, bn);
      chk({vt[i].nm, "_lat"}, 32'(lat), 32'd33);
      chk({vt[i].nm, "_busy"}, 32'(bn), 32'd33);
      chk({vt[i].nm, "_hi"}, hi, vt[i].eh);
      chk({vt[i].nm, "_lo"}, lo, vt[i].el);
    end
    @(posedge clk);
    #1;
    chk("done_one_cycle", 32'(done), 32'd0);

    // MT write in the same cycle as an accepted start
    hi_we = 1'b1;
    lo_we = 1'b1;
    wdata = 32'h55;
    launch(2'd1, 32'd2, 32'd3);
    chk("mt_start_hi", hi, 32'h55);
    chk("mt_start_lo", lo, 32'h55);
    wait_done(0, lat, bn);
    chk("mt_start_lat", 32'(lat), 32'd33);
    chk("mt_start_res", lo, 32'd6);

    // Start and MT write during busy are ignored
    launch(2'd1, 32'd6, 32'd7);
    repeat (5) begin
      @(posedge clk);
      #1;
    end
    start = 1'b1;
    op    = 2'd3;
    a     = 32'd100;
    b     = 32'd3;
    @(posedge clk);
    #1;
    start = 1'b0;
    repeat (4) begin
      @(posedge clk);
      #1;
    end
    hi_we = 1'b1;
    wdata = 32'hDEAD;
    @(posedge clk);
    #1;
    hi_we = 1'b0;
    chk("busy_mt_ign", hi, 32'h0);
    wait_done(11, lat, bn);
    chk("ign_lat", 32'(lat), 32'd33);
    chk("ign_hi", hi, 32'h0);
    chk("ign_lo", lo, 32'd42);
    hi_we = 1'b1;
    wdata = 32'h1234;
    @(posedge clk);
    #1;
    hi_we = 1'b0;
    chk("post_mt_hi", hi, 32'h1234);
    chk("post_mt_lo", lo, 32'd42);

    // Reset mid-operation
    launch(2'd3, 32'd100, 32'd7);
    repeat (11) begin
      @(posedge clk);
      #1;
    end
    reset_n = 1'b0;
    @(posedge clk);
    #1;
    reset_n = 1'b1;
    chk("mid_rst_busy", 32'(busy), 32'd0);
    chk("mid_rst_done", 32'(done), 32'd0);
    chk("mid_rst_hi", hi, 32'h0);
    chk("mid_rst_lo", lo, 32'h0);
    dn = 0;
    repeat (40) begin
      @(posedge clk);
      #1;
      if (done || busy) dn++;
    end
    chk("mid_rst_nodone", 32'(dn), 32'd0);
    do_op(2'd1, 32'd2, 32'd3, lat, bn);
    chk("after_rst_lat", 32'(lat), 32'd33);
    chk("after_rst_hi", hi, 32'h0);
    chk("after_rst_lo", lo, 32'd6);

    // Random ops against the reference model
    xs = 32'h0;
    ys = 32'h0;
    for (int i = 0; i < 150; i++) begin
      xs = xs + 32'h23456789;
      ys = ys + 32'h34567891;
      ro = 2'($urandom_range(0, 3));
      ra = (i % 3 == 0) ? $urandom : xs;
      case (i % 7)
        0:       rb = 32'h0;
        1:       rb = 32'($urandom_range(1, 15));
        2:       rb = 32'hFFFFFFFF;
        3:       rb = $urandom;
        default: rb = ys;
      endcase
      r = ref_model(ro, ra, rb);
      do_op(ro, ra, rb, lat, bn);
      chk($sformatf("rnd%0d_lat", i), 32'(lat), 32'd33);
      chk($sformatf("rnd%0d_hi op%0d a%h b%h", i, ro, ra, rb),
          hi, r[63:32]);
      chk($sformatf("rnd%0d_lo op%0d a%h b%h", i, ro, ra, rb),
          lo, r[31:0]);
    end

    chk("busy_done_overlap", 32'(ovl), 32'd0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
